// File: rtl/ffnn_pkg.sv
// rtl/ffnn_pkg.sv - shared constants, FSM states and ReLU/saturation helper for the ffnn layers
package ffnn_pkg;

   localparam int DW   = 8;
   localparam int ACCW = 18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Negative sums clamp to zero, large sums clamp to max_v, everything else passes the low DW bits.
   function automatic logic [DW-1:0] relu_sat(input logic signed [ACCW-1:0] r,
                                              input logic signed [ACCW-1:0] max_v);
      logic [DW-1:0] res;
      if (r < 0) begin
         res = '0;
      end else if (r > max_v) begin
         res = max_v[DW-1:0];
      end else begin
         res = r[DW-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/ffnn_mac.sv
// rtl/ffnn_mac.sv - signed DW x DW multiply-accumulate with bias load
module ffnn_mac #(
   parameter int DW   = 8,
   parameter int ACCW = 18
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_i,
   input  logic signed [DW-1:0]   bias_i,
   input  logic                   acc_en_i,
   input  logic signed [DW-1:0]   a_i,
   input  logic signed [DW-1:0]   b_i,
   output logic signed [ACCW-1:0] sum_o
);

   logic signed [2*DW-1:0] prod;
   logic signed [ACCW-1:0] acc_q, acc_d;

   assign prod  = a_i * b_i;
   assign sum_o = acc_q + ACCW'(prod);

   // A bias load wins over accumulation so the last MAC of one neuron can seed the next.
   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = ACCW'(bias_i);
      end else if (acc_en_i) begin
         acc_d = sum_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/ffnn_output_layer.sv
// rtl/ffnn_output_layer.sv - two-neuron output layer on one shared MAC with ReLU, saturation and argmax
module ffnn_output_layer #(
   parameter int DW      = 8,
   parameter int ACCW    = 18,
   parameter int OUT_MAX = 127
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] h0,
   input  logic signed [DW-1:0] h1,
   input  logic signed [DW-1:0] h2,
   input  logic signed [DW-1:0] h0w0,
   input  logic signed [DW-1:0] h1w0,
   input  logic signed [DW-1:0] h2w0,
   input  logic signed [DW-1:0] h0w1,
   input  logic signed [DW-1:0] h1w1,
   input  logic signed [DW-1:0] h2w1,
   input  logic signed [DW-1:0] o0b,
   input  logic signed [DW-1:0] o1b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        o0,
   output logic [DW-1:0]        o1,
   output logic                 cls
);

   import ffnn_pkg::*;

   localparam logic signed [ACCW-1:0] OUT_MAX_A = ACCW'(OUT_MAX);

   state_e                 state_q, state_d;
   logic [1:0]             k_q, k_d;
   logic                   n_q, n_d;
   logic signed [DW-1:0]   h_q  [3], h_d  [3];
   logic signed [DW-1:0]   w0_q [3], w0_d [3];
   logic signed [DW-1:0]   w1_q [3], w1_d [3];
   logic signed [DW-1:0]   o1b_q, o1b_d;
   logic [DW-1:0]          o0_q, o0_d, o1_q, o1_d;
   logic                   cls_q, cls_d;
   logic                   out_valid_q, out_valid_d;

   logic                   mac_load, mac_acc;
   logic signed [DW-1:0]   mac_bias, h_sel, w_sel;
   logic signed [ACCW-1:0] mac_sum;
   logic [DW-1:0]          o_res;

   ffnn_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (mac_load),
      .bias_i   (mac_bias),
      .acc_en_i (mac_acc),
      .a_i      (h_sel),
      .b_i      (w_sel),
      .sum_o    (mac_sum)
   );

   always_comb begin
      h_sel = h_q[2];
      w_sel = n_q ? w1_q[2] : w0_q[2];
      if (k_q == 2'd0) begin
         h_sel = h_q[0];
         w_sel = n_q ? w1_q[0] : w0_q[0];
      end else if (k_q == 2'd1) begin
         h_sel = h_q[1];
         w_sel = n_q ? w1_q[1] : w0_q[1];
      end
   end

   assign o_res = relu_sat(mac_sum, OUT_MAX_A);

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      n_d         = n_q;
      h_d         = h_q;
      w0_d        = w0_q;
      w1_d        = w1_q;
      o1b_d       = o1b_q;
      o0_d        = o0_q;
      o1_d        = o1_q;
      cls_d       = cls_q;
      out_valid_d = out_valid_q;
      mac_load    = 1'b0;
      mac_acc     = 1'b0;
      mac_bias    = o1b_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               h_d      = '{h0, h1, h2};
               w0_d     = '{h0w0, h1w0, h2w0};
               w1_d     = '{h0w1, h1w1, h2w1};
               o1b_d    = o1b;
               mac_load = 1'b1;
               mac_bias = o0b;
               k_d      = 2'd0;
               n_d      = 1'b0;
               state_d  = MAC;
            end
         end
         MAC: begin
            mac_acc = 1'b1;
            k_d     = k_q + 2'd1;
            if (k_q == 2'd2) begin
               k_d = 2'd0;
               if (!n_q) begin
                  o0_d     = o_res;
                  mac_load = 1'b1;
                  n_d      = 1'b1;
               end else begin
                  o1_d        = o_res;
                  cls_d       = (o_res > o0_q);
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         n_q         <= 1'b0;
         h_q         <= '{default: '0};
         w0_q        <= '{default: '0};
         w1_q        <= '{default: '0};
         o1b_q       <= '0;
         o0_q        <= '0;
         o1_q        <= '0;
         cls_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         n_q         <= n_d;
         h_q         <= h_d;
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         o1b_q       <= o1b_d;
         o0_q        <= o0_d;
         o1_q        <= o1_d;
         cls_q       <= cls_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign o0        = o0_q;
   assign o1        = o1_q;
   assign cls       = cls_q;

endmodule

// File: tb/tb_ffnn_output_layer.sv
// tb/tb_ffnn_output_layer.sv - self-checking bench for ffnn_output_layer
module tb_ffnn_output_layer;

   typedef struct {
      byte h  [3];
      byte w0 [3];
      byte w1 [3];
      byte b0;
      byte b1;
      int  e0;
      int  e1;
      int  ec;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic signed [7:0] h0 = '0, h1 = '0, h2 = '0;
   logic signed [7:0] h0w0 = '0, h1w0 = '0, h2w0 = '0;
   logic signed [7:0] h0w1 = '0, h1w1 = '0, h2w1 = '0;
   logic signed [7:0] o0b = '0, o1b = '0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [7:0] o0, o1;
   logic cls;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ffnn_output_layer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .h0(h0), .h1(h1), .h2(h2),
      .h0w0(h0w0), .h1w0(h1w0), .h2w0(h2w0),
      .h0w1(h0w1), .h1w1(h1w1), .h2w1(h2w1),
      .o0b(o0b), .o1b(o1b),
      .out_valid(out_valid), .out_ready(out_ready),
      .o0(o0), .o1(o1), .cls(cls)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int clamp(input int r);
      if (r < 0) return 0;
      if (r > 127) return 127;
      return r;
   endfunction

   // Reference: dot product plus bias, then ReLU/saturate, argmax with ties to class 0.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int s0 = int'(v.b0);
      int s1 = int'(v.b1);
      for (int i = 0; i < 3; i++) begin
         s0 += int'(v.h[i]) * int'(v.w0[i]);
         s1 += int'(v.h[i]) * int'(v.w1[i]);
      end
      r.e0 = clamp(s0);
      r.e1 = clamp(s1);
      r.ec = (r.e1 > r.e0) ? 1 : 0;
      return r;
   endfunction

   function automatic vec_t mk(input byte a0, a1, a2, input byte x0, x1, x2,
                               input byte y0, y1, y2, input byte b0, b1,
                               input int e0, e1, ec);
      vec_t v;
      v.h = '{a0, a1, a2}; v.w0 = '{x0, x1, x2}; v.w1 = '{y0, y1, y2};
      v.b0 = b0; v.b1 = b1; v.e0 = e0; v.e1 = e1; v.ec = ec;
      return v;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      for (int i = 0; i < 3; i++) begin
         v.h[i]  = byte'($urandom);
         v.w0[i] = byte'($urandom);
         v.w1[i] = byte'($urandom);
      end
      v.b0 = byte'($urandom);
      v.b1 = byte'($urandom);
      return model(v);
   endfunction

   task automatic drive(input vec_t v);
      h0 = v.h[0]; h1 = v.h[1]; h2 = v.h[2];
      h0w0 = v.w0[0]; h1w0 = v.w0[1]; h2w0 = v.w0[2];
      h0w1 = v.w1[0]; h1w1 = v.w1[1]; h2w1 = v.w1[2];
      o0b = v.b0; o1b = v.b1;
   endtask

   task automatic wait_ready(input string name);
      int t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      check({name, "_in_ready_timeout"}, int'(in_ready), 1);
   endtask

   // Accepts v, optionally scrambles inputs during MAC, returns cycles from accept edge to out_valid.
   task automatic accept_and_wait(input vec_t v, input bit scramble, input string name, output int lat);
      wait_ready(name);
      drive(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 30) begin
         if (scramble) drive(rnd_vec());
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input bit scramble, input string name);
      int lat;
      out_ready = 1'b1;
      accept_and_wait(v, scramble, name, lat);
      check({name, "_latency"}, lat, 6);
      check({name, "_o0"}, int'(o0), v.e0);
      check({name, "_o1"}, int'(o1), v.e1);
      check({name, "_cls"}, int'(cls), v.ec);
      @(posedge clk); #1;
      check({name, "_valid_drop"}, int'(out_valid), 0);
      check({name, "_ready_back"}, int'(in_ready), 1);
   endtask

   vec_t tbl [5];

   initial begin
      vec_t v, other;
      int   lat;
      logic [7:0] s0, s1;
      logic sc;

      tbl[0] = mk(0, 11, 10,  1, 1, 1,  2, -1, -1,  1, 0,  22, 0, 0);
      tbl[1] = mk(127, 127, 127,  127, 127, 127,  127, 127, 127,  127, 127,  127, 127, 0);
      tbl[2] = mk(127, 127, 127,  -1, -1, -1,  127, 127, 127,  127, 127,  0, 127, 1);
      tbl[3] = mk(-128, -128, -128,  -128, -128, -128,  -128, -128, -128,  -128, -128,  127, 127, 0);
      tbl[4] = mk(3, -2, 5,  4, 7, -1,  -3, 2, 6,  -10, 20,  0, 37, 1);

      #2;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_o0", int'(o0), 0);
      check("reset_o1", int'(o1), 0);
      check("reset_cls", int'(cls), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_in_ready", int'(in_ready), 1);

      for (int i = 0; i < 5; i++) run_vec(tbl[i], 1'b0, $sformatf("tbl%0d", i));

      for (int i = 0; i < 20; i++) run_vec(rnd_vec(), 1'b0, $sformatf("rnd%0d", i));

      for (int i = 0; i < 4; i++) run_vec(rnd_vec(), 1'b1, $sformatf("iso%0d", i));

      // Backpressure: hold result in DONE while offering a new vector that must be refused.
      v = model(mk(5, 6, 7, 1, 2, 3, -1, 4, 2, 9, -5, 0, 0, 0));
      other = model(mk(-100, 50, 20, 9, 9, 9, 9, 9, 9, 0, 0, 0, 0, 0));
      out_ready = 1'b0;
      accept_and_wait(v, 1'b0, "bp", lat);
      check("bp_latency", lat, 6);
      s0 = o0; s1 = o1; sc = cls;
      check("bp_o0", int'(s0), v.e0);
      check("bp_o1", int'(s1), v.e1);
      drive(other);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold_valid%0d", i), int'(out_valid), 1);
         check($sformatf("bp_hold_ready%0d", i), int'(in_ready), 0);
         check($sformatf("bp_hold_o0_%0d", i), int'(o0), int'(s0));
         check($sformatf("bp_hold_o1_%0d", i), int'(o1), int'(s1));
         check($sformatf("bp_hold_cls%0d", i), int'(cls), int'(sc));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", int'(out_valid), 0);
      check("bp_release_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      check("bp_no_stray_accept", int'(in_ready), 1);

      // Reset during neuron-1 MAC: results must clear at once and never be presented.
      v = model(mk(20, 30, 40, 1, 1, 1, 1, 1, 1, 5, 5, 0, 0, 0));
      wait_ready("rst");
      drive(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_o0_before", int'(o0), v.e0);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_o0", int'(o0), 0);
      check("rst_o1", int'(o1), 0);
      check("rst_cls", int'(cls), 0);
      check("rst_valid", int'(out_valid), 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid_held", int'(out_valid), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", int'(in_ready), 1);
      run_vec(tbl[0], 1'b0, "post_rst0");
      run_vec(rnd_vec(), 1'b0, "post_rst1");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
